rs232_tx_ctrl: RTL and testbench

Transmit scheduler that sits in front of rs232_tx. It buffers bytes from a producer in a small synchronous FIFO and applies the baud/parity configuration only while the transmitter is idle. It drives rs232_tx's start/data/config inputs one byte at a time and waits for end-of-transmission before issuing the next byte. An optional inter-byte idle gap is inserted between bytes.

---
 rtl/rs232_tx_ctrl.sv | 129 ++++++++++++
 tb/tb_rs232_tx_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_tx_ctrl.sv
// Transmit scheduler in front of rs232_tx: buffers bytes in a small FIFO and
// hands them to the transmitter one frame at a time, with an optional idle gap.
module rs232_tx_ctrl #(
  parameter int Width = 15,
  parameter int AddrW = 3,
  parameter int GapW  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [7:0]       wd_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [AddrW:0]   cnt_o,
  input  logic             cfg_we_i,
  input  logic [Width-1:0] baud_cfg_i,
  input  logic             psel_cfg_i,
  input  logic [GapW-1:0]  gap_i,
  output logic [Width-1:0] baud_o,
  output logic             psel_o,
  output logic             st_o,
  output logic [7:0]       d_o,
  input  logic             eot_i,
  output logic             busy_o
);

  localparam int Depth = 2 ** AddrW;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    GAP
  } state_t;

  state_t state, state_next;

  logic [7:0]       mem [Depth];
  logic [AddrW-1:0] wr_ptr, rd_ptr;
  logic [GapW-1:0]  gap_cnt;
  logic             push, pop, cfg_load, gap_load;

  assign push    = wr_i & ~full_o;
  assign full_o  = (cnt_o == (AddrW + 1)'(Depth));
  assign empty_o = (cnt_o == '0);
  assign busy_o  = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // A config write in IDLE wins over a pending byte so the new settings apply to it.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    cfg_load   = 1'b0;
    gap_load   = 1'b0;
    st_o       = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_we_i)      cfg_load   = 1'b1;
        else if (!empty_o) state_next = LOAD;
      end
      LOAD: begin
        pop        = 1'b1;
        state_next = START;
      end
      START: begin
        st_o       = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (eot_i) begin
          if (gap_i == '0) begin
            state_next = IDLE;
          end else begin
            gap_load   = 1'b1;
            state_next = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt <= GapW'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wd_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_o  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AddrW'(1);
      if (pop)  rd_ptr <= rd_ptr + AddrW'(1);
      case ({push, pop})
        2'b10:   cnt_o <= cnt_o + (AddrW + 1)'(1);
        2'b01:   cnt_o <= cnt_o - (AddrW + 1)'(1);
        default: cnt_o <= cnt_o;
      endcase
    end
  end

  // Data and line settings only move between frames, so rs232_tx sees them stable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_o     <= '0;
      baud_o  <= Width'(10415);
      psel_o  <= 1'b0;
      gap_cnt <= '0;
    end else begin
      if (pop) d_o <= mem[rd_ptr];
      if (cfg_load) begin
        baud_o <= baud_cfg_i;
        psel_o <= psel_cfg_i;
      end
      if (gap_load)          gap_cnt <= gap_i;
      else if (state == GAP) gap_cnt <= gap_cnt - GapW'(1);
    end
  end

endmodule

// File: tb/tb_rs232_tx_ctrl.sv
// Self-checking bench for rs232_tx_ctrl: a cycle-level behavioural model of
// the scheduler plus directed scenarios with hand-computed expectations.
module tb_rs232_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst, wr, cfg_we, psel_cfg, eot;
  logic [7:0]  wd;
  logic [14:0] baud_cfg;
  logic [7:0]  gap;
  logic        full, empty, psel, st, busy;
  logic [3:0]  cnt;
  logic [14:0] baud;
  logic [7:0]  d;

  int checks = 0;
  int passes = 0;

  rs232_tx_ctrl dut (
    .clk_i(clk), .rst_i(rst), .wr_i(wr), .wd_i(wd), .full_o(full),
    .empty_o(empty), .cnt_o(cnt), .cfg_we_i(cfg_we), .baud_cfg_i(baud_cfg),
    .psel_cfg_i(psel_cfg), .gap_i(gap), .baud_o(baud), .psel_o(psel),
    .st_o(st), .d_o(d), .eot_i(eot), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    else             passes++;
  endtask

  // Model: FIFO as a queue; m_age counts edges since a byte was committed
  // (1 = fetching, 2 = start pulse visible, 3+ = frame on the line).
  logic [7:0]  q[$];
  int          m_age = 0, m_gap_left = 0, m_sz;
  bit          m_idle, model_on = 0;
  logic [14:0] m_baud;
  logic        m_psel;
  logic [7:0]  m_d;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_age = 0; m_gap_left = 0; m_baud = 15'd10415; m_psel = 1'b0; m_d = 8'h00;
      model_on = 1;
    end else begin
      m_sz   = q.size();
      m_idle = (m_age == 0 && m_gap_left == 0);
      if (m_age == 1) m_d = q.pop_front();
      if (wr && m_sz < 8) q.push_back(wd);
      if (m_idle) begin
        if (cfg_we) begin m_baud = baud_cfg; m_psel = psel_cfg; end
        else if (m_sz > 0) m_age = 1;
      end else if (m_age == 1 || m_age == 2) begin
        m_age++;
      end else if (m_age >= 3) begin
        if (eot) begin m_age = 0; m_gap_left = gap; end
      end else begin
        m_gap_left--;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("m_cnt",   cnt,   q.size());
      checkOutput("m_empty", empty, q.size() == 0);
      checkOutput("m_full",  full,  q.size() == 8);
      checkOutput("m_st",    st,    m_age == 2);
      checkOutput("m_busy",  busy,  !(m_age == 0 && m_gap_left == 0));
      checkOutput("m_baud",  baud,  m_baud);
      checkOutput("m_psel",  psel,  m_psel);
      checkOutput("m_d",     d,     m_d);
    end
  end

  task automatic applyStimulus(input logic w, input logic [7:0] b, input logic c, input logic e);
    wr = w; wd = b; cfg_we = c; eot = e;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pulseEot();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    eot = 1'b0;
  endtask

  task automatic waitStart();
    int n = 0;
    while (st !== 1'b1 && n < 40) begin idle(1); n++; end
    checkOutput("st_seen", st, 1'b1);
  endtask

  logic [7:0] burst [3] = '{8'h41, 8'h42, 8'h43};

  initial begin
    int n;
    rst = 1'b1; wr = 1'b1; wd = 8'hAA; cfg_we = 1'b0; eot = 1'b0;
    gap = 8'd0; baud_cfg = 15'd0; psel_cfg = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_cnt", cnt, 0);
    checkOutput("rst_st", st, 0);
    checkOutput("rst_baud", baud, 10415);
    checkOutput("rst_psel", psel, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_empty", empty, 1);

    $display("[TB] single byte");
    applyStimulus(1'b1, 8'h73, 1'b0, 1'b0);
    checkOutput("s1_cnt", cnt, 1);
    checkOutput("s1_busy", busy, 0);
    idle(1);
    checkOutput("s2_busy", busy, 1);
    checkOutput("s2_st", st, 0);
    idle(1);
    checkOutput("s3_st", st, 1);
    checkOutput("s3_d", d, 8'h73);
    idle(1);
    checkOutput("s4_st", st, 0);
    idle(3);
    checkOutput("s_hold_d", d, 8'h73);
    pulseEot();
    checkOutput("s_eot_busy", busy, 0);
    checkOutput("s_eot_empty", empty, 1);

    $display("[TB] burst");
    gap = 8'd0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, burst[i], 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      waitStart();
      checkOutput("burst_d", d, burst[k]);
      idle(3);
      pulseEot();
      if (k < 2) begin
        n = 0;
        while (st !== 1'b1 && n < 20) begin idle(1); n++; end
        checkOutput("burst_eot_to_st", n, 2);
      end
    end
    idle(2);

    $display("[TB] full and wrap");
    baud_cfg = 15'd10415; psel_cfg = 1'b0;
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
    checkOutput("full_cnt", cnt, 8);
    checkOutput("full_flag", full, 1);
    checkOutput("full_busy", busy, 0);
    idle(1);
    for (int k = 0; k < 8; k++) begin
      waitStart();
      checkOutput("wrap_d", d, 8'h11 + 8'(k));
      idle(2);
      pulseEot();
    end
    idle(2);
    checkOutput("wrap_empty", empty, 1);

    $display("[TB] config gating");
    baud_cfg = 15'd868; psel_cfg = 1'b1;
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    waitStart();
    idle(1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("wait_cfg_psel", psel, 0);
    checkOutput("wait_cfg_baud", baud, 10415);
    idle(1);
    pulseEot();
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("idle_cfg_psel", psel, 1);
    checkOutput("idle_cfg_baud", baud, 868);
    checkOutput("idle_cfg_busy", busy, 0);
    idle(1);
    checkOutput("defer_busy", busy, 1);
    checkOutput("defer_st", st, 0);
    idle(1);
    checkOutput("defer_st2", st, 1);
    checkOutput("defer_d", d, 8'h66);
    idle(2);
    pulseEot();

    $display("[TB] gap");
    gap = 8'd5;
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    waitStart();
    idle(2);
    pulseEot();
    gap = 8'd0;
    n = 0;
    while (busy === 1'b1 && n < 50) begin idle(1); n++; end
    checkOutput("gap_cycles", n, 5);

    $display("[TB] mid-frame reset");
    applyStimulus(1'b1, 8'h88, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    waitStart();
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_empty", empty, 1);
    checkOutput("mrst_d", d, 0);
    checkOutput("mrst_baud", baud, 10415);
    pulseEot();
    checkOutput("mrst_eot_busy", busy, 0);
    idle(2);
    checkOutput("mrst_eot_st", st, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
